// File: rtl/reg_dump_engine.sv
// Halt-triggered register file dump engine. It walks the register file's asynchronous
// read port from x0 upward, emits each register on a valid/ready stream, and accumulates
// an additive checksum of the accepted words.
module reg_dump_engine #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [4:0]            rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [4:0]            dump_idx,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_last,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [4:0]            idx_q, idx_d;
  logic [4:0]            didx_q, didx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] cks_q, cks_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      didx_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cks_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      didx_q  <= didx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cks_q   <= cks_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    didx_d  = didx_q;
    data_d  = data_q;
    valid_d = valid_q;
    cks_d   = cks_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          cks_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Capture happens only here; later writes to this register cannot leak into the word.
        data_d  = rf_rdata;
        didx_d  = idx_q;
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (dump_ready) begin
          cks_d   = cks_q + data_q;
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rf_raddr   = (state_q == S_LOAD || state_q == S_SEND) ? idx_q : '0;
  assign dump_valid = valid_q;
  assign dump_idx   = didx_q;
  assign dump_data  = data_q;
  assign dump_last  = valid_q && (didx_q == LAST_IDX);
  assign busy       = (state_q == S_LOAD) || (state_q == S_SEND);
  assign done       = (state_q == S_DONE);
  assign checksum   = cks_q;

endmodule
